// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control FSM with memory ready/stall handshake and illegal-op detection.
// Define CTRL_RETIRE_CNT_EN to add the retire_cnt/stall_cnt performance counters.
module multicycle_control_unit #(
   parameter int unsigned OP_W    = 6,
   parameter int unsigned FUNCT_W = 6,
   parameter int unsigned ALUC_W  = 3,
   parameter int unsigned CNT_W   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OP_W-1:0]    op,
   input  logic [FUNCT_W-1:0] funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pcen,
   output logic               iord,
   output logic               memwrite,
   output logic               irwrite,
   output logic               regdst,
   output logic               memtoreg,
   output logic               regwrite,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         pcsrc,
   output logic [ALUC_W-1:0]  alucontrol,
   output logic               illegal_op,
`ifdef CTRL_RETIRE_CNT_EN
   output logic [3:0]         state,
   output logic [CNT_W-1:0]   retire_cnt,
   output logic [CNT_W-1:0]   stall_cnt
`else
   output logic [3:0]         state
`endif
);

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExecute = 4'd6,
      StAluWb   = 4'd7,
      StBranch  = 4'd8,
      StAddiEx  = 4'd9,
      StAddiWb  = 4'd10,
      StJump    = 4'd11
   } state_e;

   // Full-width compares: upper opcode/funct bits must be zero to match.
   localparam logic [OP_W-1:0]    OpRtype = OP_W'(6'b000000);
   localparam logic [OP_W-1:0]    OpLw    = OP_W'(6'b100011);
   localparam logic [OP_W-1:0]    OpSw    = OP_W'(6'b101011);
   localparam logic [OP_W-1:0]    OpBeq   = OP_W'(6'b000100);
   localparam logic [OP_W-1:0]    OpAddi  = OP_W'(6'b001000);
   localparam logic [OP_W-1:0]    OpJ     = OP_W'(6'b000010);

   localparam logic [FUNCT_W-1:0] FnAdd   = FUNCT_W'(6'b100000);
   localparam logic [FUNCT_W-1:0] FnSub   = FUNCT_W'(6'b100010);
   localparam logic [FUNCT_W-1:0] FnAnd   = FUNCT_W'(6'b100100);
   localparam logic [FUNCT_W-1:0] FnOr    = FUNCT_W'(6'b100101);
   localparam logic [FUNCT_W-1:0] FnSlt   = FUNCT_W'(6'b101010);

   localparam logic [ALUC_W-1:0]  AlucAnd = ALUC_W'(3'b000);
   localparam logic [ALUC_W-1:0]  AlucOr  = ALUC_W'(3'b001);
   localparam logic [ALUC_W-1:0]  AlucAdd = ALUC_W'(3'b010);
   localparam logic [ALUC_W-1:0]  AlucSub = ALUC_W'(3'b110);
   localparam logic [ALUC_W-1:0]  AlucSlt = ALUC_W'(3'b111);

   state_e r_state;
   state_e w_state_next;
   logic   w_pcwrite;
   logic   w_branch;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StFetch;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = StFetch;
      w_pcwrite    = 1'b0;
      w_branch     = 1'b0;
      iord         = 1'b0;
      memwrite     = 1'b0;
      irwrite      = 1'b0;
      regdst       = 1'b0;
      memtoreg     = 1'b0;
      regwrite     = 1'b0;
      alusrca      = 1'b0;
      alusrcb      = 2'b00;
      pcsrc        = 2'b00;
      alucontrol   = AlucAdd;
      illegal_op   = 1'b0;
      // Reset overrides the decode so nothing is written in the reset cycle.
      if (!reset) begin
         case (r_state)
            StFetch: begin
               alusrcb      = 2'b01;
               irwrite      = mem_ready;
               w_pcwrite    = mem_ready;
               w_state_next = mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
               alusrcb = 2'b11;
               if ((op == OpLw) || (op == OpSw)) begin
                  w_state_next = StMemAdr;
               end else if (op == OpRtype) begin
                  w_state_next = StExecute;
               end else if (op == OpBeq) begin
                  w_state_next = StBranch;
               end else if (op == OpAddi) begin
                  w_state_next = StAddiEx;
               end else if (op == OpJ) begin
                  w_state_next = StJump;
               end else begin
                  illegal_op   = 1'b1;
                  w_state_next = StFetch;
               end
            end
            StMemAdr: begin
               alusrca      = 1'b1;
               alusrcb      = 2'b10;
               w_state_next = (op == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
               iord         = 1'b1;
               w_state_next = mem_ready ? StMemWb : StMemRd;
            end
            StMemWb: begin
               regwrite = 1'b1;
               memtoreg = 1'b1;
            end
            StMemWr: begin
               iord         = 1'b1;
               memwrite     = mem_ready;
               w_state_next = mem_ready ? StFetch : StMemWr;
            end
            StExecute: begin
               alusrca      = 1'b1;
               w_state_next = StAluWb;
               case (funct)
                  FnAdd:   alucontrol = AlucAdd;
                  FnSub:   alucontrol = AlucSub;
                  FnAnd:   alucontrol = AlucAnd;
                  FnOr:    alucontrol = AlucOr;
                  FnSlt:   alucontrol = AlucSlt;
                  default: begin
                     illegal_op   = 1'b1;
                     w_state_next = StFetch;
                  end
               endcase
            end
            StAluWb: begin
               regwrite = 1'b1;
               regdst   = 1'b1;
            end
            StBranch: begin
               alusrca    = 1'b1;
               alucontrol = AlucSub;
               pcsrc      = 2'b01;
               w_branch   = 1'b1;
            end
            StAddiEx: begin
               alusrca      = 1'b1;
               alusrcb      = 2'b10;
               w_state_next = StAddiWb;
            end
            StAddiWb: begin
               regwrite = 1'b1;
            end
            StJump: begin
               pcsrc     = 2'b10;
               w_pcwrite = 1'b1;
            end
            default: w_state_next = StFetch;
         endcase
      end
      pcen = w_pcwrite | (w_branch & zero);
   end

   assign state = reset ? StFetch : r_state;

`ifdef CTRL_RETIRE_CNT_EN
   logic             w_retire;
   logic             w_stall;
   logic [CNT_W-1:0] r_retire_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   always_comb begin
      w_retire = 1'b0;
      w_stall  = 1'b0;
      if (!reset) begin
         case (r_state)
            StMemWb, StAluWb, StBranch, StAddiWb, StJump: w_retire = 1'b1;
            StMemWr: w_retire = mem_ready;
            default: w_retire = 1'b0;
         endcase
         w_stall = !mem_ready && (r_state inside {StFetch, StMemRd, StMemWr});
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_retire_cnt <= '0;
         r_stall_cnt  <= '0;
      end else begin
         if (w_retire) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
         if (w_stall)  r_stall_cnt  <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign retire_cnt = r_retire_cnt;
   assign stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit; counter checks when
// CTRL_RETIRE_CNT_EN is defined.
module tb_multicycle_control_unit;

`ifdef CTRL_RETIRE_CNT_EN
   localparam int unsigned TbCntW = 4;
`else
   localparam int unsigned TbCntW = 32;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic       illegal_op;
   logic [3:0] state;
`ifdef CTRL_RETIRE_CNT_EN
   logic [TbCntW-1:0] retire_cnt, stall_cnt;
   logic [TbCntW-1:0] m_cnt;
`endif

   int n_checks  = 0;
   int n_errors  = 0;
   int exp_retire = 0;
   int exp_stall  = 0;

   multicycle_control_unit #(.CNT_W(TbCntW)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pcen       (pcen),
      .iord       (iord),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .regwrite   (regwrite),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .alucontrol (alucontrol),
      .illegal_op (illegal_op),
`ifdef CTRL_RETIRE_CNT_EN
      .state      (state),
      .retire_cnt (retire_cnt),
      .stall_cnt  (stall_cnt)
`else
      .state      (state)
`endif
   );

   always #5 clk = ~clk;

   // {pcen, irwrite, memwrite, regwrite, illegal_op, memtoreg, regdst, iord}
   wire [7:0] w_en = {pcen, irwrite, memwrite, regwrite, illegal_op, memtoreg, regdst, iord};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input string tag, input logic mr, input logic [3:0] st, input logic [7:0] en);
      mem_ready = mr;
      #1;
      check({tag, "/state"}, 32'(state), 32'(st));
      check({tag, "/en"}, 32'(w_en), 32'(en));
      if (!reset && !mr && (st == 4'd0 || st == 4'd3 || st == 4'd5)) exp_stall++;
   endtask

   task automatic fetch_decode(input string tag);
      cyc({tag, "/fetch"}, 1'b1, 4'd0, 8'hC0);
      step();
      cyc({tag, "/decode"}, 1'b1, 4'd1, 8'h00);
      check({tag, "/dec_srcb"}, 32'(alusrcb), 32'd3);
      step();
   endtask

   task automatic do_jump(input string tag);
      op = 6'b000010;
      fetch_decode(tag);
      cyc({tag, "/jump"}, 1'b1, 4'd11, 8'h80);
      check({tag, "/jump_pcsrc"}, 32'(pcsrc), 32'd2);
      step();
      exp_retire++;
   endtask

   initial begin
      reset = 1'b1; op = 6'b000000; funct = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
      step(); step();
      cyc("rst0", 1'b1, 4'd0, 8'h00);
      check("rst0/aluc", 32'(alucontrol), 32'd2);
      reset = 1'b0;
      fetch_decode("pre");
      cyc("pre/ex", 1'b1, 4'd6, 8'h00);
      // Abort the R-type in EXECUTE with a 2-cycle reset.
      reset = 1'b1;
      cyc("rstex1", 1'b1, 4'd0, 8'h00);
      check("rstex1/aluc", 32'(alucontrol), 32'd2);
      check("rstex1/srca", 32'(alusrca), 32'd0);
      step();
      cyc("rstex2", 1'b1, 4'd0, 8'h00);
      step();
      reset = 1'b0;
      cyc("fhold1", 1'b0, 4'd0, 8'h00);
      step();
      cyc("fhold2", 1'b0, 4'd0, 8'h00);
      step();

      // add
      fetch_decode("add");
      cyc("add/ex", 1'b1, 4'd6, 8'h00);
      check("add/aluc", 32'(alucontrol), 32'd2);
      step();
      cyc("add/wb", 1'b1, 4'd7, 8'h12);
      step();
      exp_retire++;

      // lw
      op = 6'b100011;
      fetch_decode("lw");
      cyc("lw/adr", 1'b1, 4'd2, 8'h00);
      check("lw/srcb", 32'(alusrcb), 32'd2);
      check("lw/srca", 32'(alusrca), 32'd1);
      step();
      cyc("lw/rd", 1'b1, 4'd3, 8'h01);
      step();
      cyc("lw/wb", 1'b1, 4'd4, 8'h14);
      step();
      exp_retire++;

      // sw with 3 stall cycles in MEMWR
      op = 6'b101011;
      fetch_decode("sw");
      cyc("sw/adr", 1'b1, 4'd2, 8'h00);
      step();
      for (int i = 0; i < 3; i++) begin
         cyc("sw/stall", 1'b0, 4'd5, 8'h01);
         step();
      end
      cyc("sw/wr", 1'b1, 4'd5, 8'h21);
      step();
      exp_retire++;

      // slt
      op = 6'b000000; funct = 6'b101010;
      fetch_decode("slt");
      cyc("slt/ex", 1'b1, 4'd6, 8'h00);
      check("slt/aluc", 32'(alucontrol), 32'd7);
      step();
      cyc("slt/wb", 1'b1, 4'd7, 8'h12);
      step();
      exp_retire++;

      // unknown funct
      funct = 6'b111111;
      fetch_decode("badfn");
      cyc("badfn/ex", 1'b1, 4'd6, 8'h08);
      step();

      // beq taken / not taken
      op = 6'b000100; zero = 1'b1;
      fetch_decode("beq1");
      cyc("beq1/br", 1'b1, 4'd8, 8'h80);
      check("beq1/pcsrc", 32'(pcsrc), 32'd1);
      check("beq1/aluc", 32'(alucontrol), 32'd6);
      step();
      exp_retire++;
      zero = 1'b0;
      fetch_decode("beq0");
      cyc("beq0/br", 1'b1, 4'd8, 8'h00);
      step();
      exp_retire++;

      // addi
      op = 6'b001000;
      fetch_decode("addi");
      cyc("addi/ex", 1'b1, 4'd9, 8'h00);
      check("addi/srcb", 32'(alusrcb), 32'd2);
      step();
      cyc("addi/wb", 1'b1, 4'd10, 8'h10);
      step();
      exp_retire++;

      do_jump("j");

      // illegal opcode
      op = 6'b111111;
      cyc("badop/fetch", 1'b1, 4'd0, 8'hC0);
      step();
      cyc("badop/decode", 1'b1, 4'd1, 8'h08);
      step();
      cyc("badop/back", 1'b0, 4'd0, 8'h00);
      step();

`ifdef CTRL_RETIRE_CNT_EN
      m_cnt = TbCntW'(exp_retire);
      check("retire_cnt", 32'(retire_cnt), 32'(m_cnt));
      m_cnt = TbCntW'(exp_stall);
      check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      while ((exp_retire % 16) != 15) do_jump("jfill");
      check("retire_15", 32'(retire_cnt), 32'd15);
      do_jump("jwrap");
      check("retire_wrap", 32'(retire_cnt), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised multicycle MIPS-subset control FSM for the ECE 251 CPU datapath.
- Decodes opcode/funct and sequences fetch, decode, execute, memory and writeback.
- Drives all datapath enables and muxes.
- Adds over the single-cycle decoder: a memory ready/stall handshake, illegal-opcode detection, a debug state output, and an optional retire counter.

Parameters:
OP_W, 6, opcode field width
FUNCT_W, 6, funct field width
ALUC_W, 3, ALU control width
CNT_W, 32, retire counter width (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous active-high reset
op  input  OP_W  instruction opcode (instr[31:26])
funct  input  FUNCT_W  R-type funct (instr[5:0])
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes access this cycle
pcen  output  1  PC load enable = pcwrite | (branch & zero)
iord  output  1  0=PC addresses memory, 1=ALUOut
memwrite  output  1  memory write strobe
irwrite  output  1  instruction register load
regdst  output  1  0=rt, 1=rd destination
memtoreg  output  1  0=ALUOut, 1=MDR writeback
regwrite  output  1  register file write
alusrca  output  1  0=PC, 1=A
alusrcb  output  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
pcsrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
alucontrol  output  ALUC_W  ALU operation
illegal_op  output  1  one-cycle pulse on unsupported opcode/funct
state  output  4  current FSM state (debug)

Behaviour:
- Reset: state=FETCH(0). While reset=1, all enables (pcen, irwrite, memwrite, regwrite) are 0; muxes are 0; alucontrol=010; illegal_op=0.
- Reset applied mid-instruction aborts it. No write occurs in the reset cycle.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12-15 are unused and go to FETCH.
- Outputs are Moore, decoded from state, except that memory-stage enables are gated by mem_ready.
- FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00.
  - irwrite and pcwrite are asserted only when mem_ready=1; the FSM then moves to DECODE.
  - With mem_ready=0 the FSM holds in FETCH with no writes.
- DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut). Next state by opcode:
  - 100011 lw or 101011 sw -> MEMADR
  - 000000 R-type -> EXECUTE
  - 000100 beq -> BRANCH
  - 001000 addi -> ADDIEX
  - 000010 j -> JUMP
  - any other opcode -> FETCH, with illegal_op=1 for this cycle only
- MEMADR: alusrca=1, alusrcb=10, add. lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord=1; wait for mem_ready=1, then -> MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1 -> FETCH.
- MEMWR: iord=1, memwrite=mem_ready; wait for mem_ready=1, then -> FETCH. memwrite is never asserted for more than one accepted cycle.
- EXECUTE: alusrca=1, alusrcb=00. alucontrol from funct:
  - 100000 add -> 010
  - 100010 sub -> 110
  - 100100 and -> 000
  - 100101 or -> 001
  - 101010 slt -> 111
  - unknown funct: illegal_op=1, -> FETCH, no writeback
  - known funct -> ALUWB
- ALUWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1 (pcen=zero) -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add -> ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
- JUMP: pcsrc=10, pcwrite=1 -> FETCH.
- Cycle counts with mem_ready tied high:
  - lw 5, sw 4, R 4, addi 4, beq 3, j 3
  - each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds 1
- ALUC_W>3: alucontrol is zero-extended. Opcode/funct compares use the low 6 bits; any upper bits must be 0 or the instruction is illegal.

Optional Feature:
- Macro: CTRL_RETIRE_CNT_EN.
- When defined, adds ports:
  - retire_cnt output CNT_W: instructions completed. Increments by 1 on entry to FETCH from MEMWB, MEMWR (accepted), ALUWB, BRANCH, ADDIWB or JUMP. Illegal instructions do not count. Wraps modulo 2^CNT_W. Cleared by reset.
  - stall_cnt output CNT_W: cycles with mem_ready=0 in FETCH/MEMRD/MEMWR. Same reset and wrap rules.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset held 2 cycles in EXECUTE -> state=0, all enables 0 on the cycle after reset; next fetch with mem_ready=1 pulses irwrite=1, pcen=1.
- lw (op=100011), mem_ready=1 -> states 0,1,2,3,4,0; regwrite=1 with memtoreg=1 only in state 4; 5 cycles.
- sw with mem_ready low 3 cycles in MEMWR -> holds state 5 for 3 cycles, memwrite=0; memwrite=1 exactly once when mem_ready=1; then FETCH.
- R-type funct=101010 -> EXECUTE alucontrol=111, then ALUWB regdst=1; funct=111111 -> illegal_op=1 one cycle, no regwrite, back to FETCH.
- beq: zero=1 -> pcen=1, pcsrc=01 in BRANCH; zero=0 -> pcen=0. op=111111 -> illegal_op pulse in DECODE, returns to FETCH.
- CTRL_RETIRE_CNT_EN: run lw, sw, add, beq, j, illegal -> retire_cnt=5. With CNT_W=4 preloaded to 15 via 15 retires, the next retire wraps to 0.
